// File: rtl/video_bank_scheduler.sv
// Ping-pong scheduler for the two video frame banks: issues fills into the hidden bank,
// swaps the displayed bank on frame boundaries, repeats frames and counts underruns.
module video_bank_scheduler #(
   parameter int FRAME_REPEAT = 2,
   parameter int NUM_FRAMES   = 6572,
   parameter int FRAME_W      = 13,
   parameter int UNDERRUN_W   = 8
) (
   input  logic                  CLK_40,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  frame_start,
   input  logic                  fill_done,
   output logic                  fill_req,
   output logic                  write_bank,
   output logic                  read_bank1,
   output logic                  read_bank2,
   output logic                  done,
   output logic [FRAME_W-1:0]    frame_count,
   output logic [UNDERRUN_W-1:0] underrun_count,
   output logic [1:0]            bank_full
);

   localparam int REP_W = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
   localparam logic [REP_W-1:0] REP_LAST  = REP_W'(FRAME_REPEAT - 1);
   // One extra bit so a clip length of exactly 2^FRAME_W cannot wrap the issue counter.
   localparam logic [FRAME_W:0] NUM_FILLS = (FRAME_W + 1)'(NUM_FRAMES);

   typedef enum logic {W_IDLE, W_BUSY} w_state_t;

   w_state_t              w_state_reg, w_state_next;
   logic [1:0]            full_reg;
   logic                  rd_sel_reg;
   logic                  rd_valid_reg;
   logic [REP_W-1:0]      repeat_cnt_reg;
   logic [FRAME_W:0]      fills_issued_reg;
   logic                  write_bank_reg;
   logic                  fill_req_reg;
   logic                  done_reg;
   logic [FRAME_W-1:0]    frame_count_reg;
   logic [UNDERRUN_W-1:0] underrun_count_reg;

   logic wr_target, fill_issue, fill_land;
   logic swap_bank, rep_advance, do_swap, do_done, do_underrun;

   always_ff @(posedge CLK_40) begin
      if (reset) begin
         w_state_reg <= W_IDLE;
      end else begin
         w_state_reg <= w_state_next;
      end
   end

   // Writer: never targets the displayed bank; before anything is shown, bank 0 fills first.
   always_comb begin
      w_state_next = w_state_reg;
      fill_issue   = 1'b0;
      fill_land    = 1'b0;
      wr_target    = rd_valid_reg ? ~rd_sel_reg : full_reg[0];
      case (w_state_reg)
         W_IDLE: begin
            if (enable && !full_reg[wr_target] && (fills_issued_reg < NUM_FILLS)) begin
               fill_issue   = 1'b1;
               w_state_next = W_BUSY;
            end
         end
         W_BUSY: begin
            if (fill_done) begin
               fill_land    = 1'b1;
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // Reader decisions use the flags as registered, so a fill landing this cycle is not yet visible.
   always_comb begin
      rep_advance = 1'b0;
      do_swap     = 1'b0;
      do_done     = 1'b0;
      do_underrun = 1'b0;
      swap_bank   = rd_valid_reg ? ~rd_sel_reg : ~full_reg[0];
      if (frame_start && enable) begin
         if (rd_valid_reg && (repeat_cnt_reg < REP_LAST)) begin
            rep_advance = 1'b1;
         end else if (full_reg[swap_bank]) begin
            do_swap = 1'b1;
         end else if ((fills_issued_reg == NUM_FILLS) && (w_state_reg == W_IDLE)) begin
            do_done = 1'b1;
         end else if (rd_valid_reg) begin
            do_underrun = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_40) begin
      if (reset) begin
         full_reg           <= 2'b00;
         rd_sel_reg         <= 1'b0;
         rd_valid_reg       <= 1'b0;
         repeat_cnt_reg     <= '0;
         fills_issued_reg   <= '0;
         write_bank_reg     <= 1'b0;
         fill_req_reg       <= 1'b0;
         done_reg           <= 1'b0;
         frame_count_reg    <= '0;
         underrun_count_reg <= '0;
      end else begin
         fill_req_reg <= fill_issue;
         if (fill_issue) begin
            write_bank_reg   <= wr_target;
            fills_issued_reg <= fills_issued_reg + 1;
         end
         // Landing and release always concern different banks, so both may apply in one cycle.
         if (fill_land) begin
            full_reg[write_bank_reg] <= 1'b1;
         end
         if (do_swap && rd_valid_reg) begin
            full_reg[rd_sel_reg] <= 1'b0;
         end
         if (rep_advance) begin
            repeat_cnt_reg <= repeat_cnt_reg + 1;
         end
         if (do_swap) begin
            rd_sel_reg      <= swap_bank;
            rd_valid_reg    <= 1'b1;
            repeat_cnt_reg  <= '0;
            frame_count_reg <= frame_count_reg + 1;
         end
         if (do_done) begin
            done_reg <= 1'b1;
         end
         if (do_underrun && (underrun_count_reg != '1)) begin
            underrun_count_reg <= underrun_count_reg + 1;
         end
      end
   end

   assign fill_req       = fill_req_reg;
   assign write_bank     = write_bank_reg;
   assign read_bank1     = rd_valid_reg & ~rd_sel_reg;
   assign read_bank2     = rd_valid_reg & rd_sel_reg;
   assign done           = done_reg;
   assign frame_count    = frame_count_reg;
   assign underrun_count = underrun_count_reg;
   assign bank_full      = full_reg;

endmodule

// File: tb/tb_video_bank_scheduler.sv
// Bench for video_bank_scheduler: directed bring-up with literal expectations, then random
// traffic checked every cycle against a behavioural model of the bank/frame rules.
module tb_video_bank_scheduler;

   localparam int FRAME_REPEAT = 2;
   localparam int NUM_FRAMES   = 12;
   localparam int FRAME_W      = 4;
   localparam int UNDERRUN_W   = 2;
   localparam int UC_MAX       = (1 << UNDERRUN_W) - 1;
   localparam int RAND_CYCLES  = 8000;

   logic                  CLK_40 = 1'b0;
   logic                  reset, enable, frame_start, fill_done;
   logic                  fill_req, write_bank, read_bank1, read_bank2, done;
   logic [FRAME_W-1:0]    frame_count;
   logic [UNDERRUN_W-1:0] underrun_count;
   logic [1:0]            bank_full;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state
   bit [1:0] m_full;
   bit       m_rd_sel, m_rd_valid, m_busy, m_wb, m_fill_req, m_done;
   int       m_rep, m_fills, m_fc, m_uc;

   video_bank_scheduler #(
      .FRAME_REPEAT(FRAME_REPEAT), .NUM_FRAMES(NUM_FRAMES),
      .FRAME_W(FRAME_W), .UNDERRUN_W(UNDERRUN_W)
   ) dut (
      .CLK_40(CLK_40), .reset(reset), .enable(enable), .frame_start(frame_start),
      .fill_done(fill_done), .fill_req(fill_req), .write_bank(write_bank),
      .read_bank1(read_bank1), .read_bank2(read_bank2), .done(done),
      .frame_count(frame_count), .underrun_count(underrun_count), .bank_full(bank_full)
   );

   always #12.5 CLK_40 = ~CLK_40;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: a fill occupies the hidden bank; the display moves to the other bank only once
   // it is full and the current frame has been shown FRAME_REPEAT times.
   always @(posedge CLK_40) begin
      bit [1:0] o_full;
      bit       o_sel, o_valid, o_busy, want;
      int       o_fills;
      if (reset) begin
         m_full = 2'b00; m_rd_sel = 0; m_rd_valid = 0; m_busy = 0; m_wb = 0;
         m_fill_req = 0; m_done = 0; m_rep = 0; m_fills = 0; m_fc = 0; m_uc = 0;
      end else begin
         o_full = m_full; o_sel = m_rd_sel; o_valid = m_rd_valid;
         o_busy = m_busy; o_fills = m_fills;
         m_fill_req = 0;
         if (o_busy) begin
            if (fill_done) begin
               m_full[m_wb] = 1;
               m_busy = 0;
            end
         end else begin
            want = o_valid ? !o_sel : o_full[0];
            if (enable && !o_full[want] && o_fills < NUM_FRAMES) begin
               m_fill_req = 1; m_wb = want; m_fills++; m_busy = 1;
            end
         end
         if (frame_start && enable) begin
            if (o_valid && m_rep < FRAME_REPEAT - 1) begin
               m_rep++;
            end else begin
               want = o_valid ? !o_sel : !o_full[0];
               if (o_full[want]) begin
                  if (o_valid) m_full[o_sel] = 0;
                  m_rd_sel = want; m_rd_valid = 1; m_rep = 0;
                  m_fc = (m_fc + 1) % (1 << FRAME_W);
               end else if (o_fills == NUM_FRAMES && !o_busy) begin
                  m_done = 1;
               end else if (o_valid) begin
                  if (m_uc < UC_MAX) m_uc++;
               end
            end
         end
      end
   end

   always @(negedge CLK_40) begin
      if (chk_en) begin
         check("fill_req", fill_req, m_fill_req);
         check("write_bank", write_bank, m_wb);
         check("read_bank1", read_bank1, m_rd_valid && !m_rd_sel);
         check("read_bank2", read_bank2, m_rd_valid && m_rd_sel);
         check("done", done, m_done);
         check("frame_count", frame_count, m_fc);
         check("underrun_count", underrun_count, m_uc);
         check("bank_full", bank_full, m_full);
      end
   end

   task automatic step();
      @(negedge CLK_40);
   endtask

   task automatic pulse_fs(input bit with_fd);
      frame_start = 1; fill_done = with_fd;
      step();
      frame_start = 0; fill_done = 0;
   endtask

   initial begin
      int fd_cd, fs_cd, off_cnt, pulses;
      reset = 1; enable = 0; frame_start = 0; fill_done = 0;
      step(); step();
      chk_en = 1;
      check("rst_fill_req", fill_req, 0);
      check("rst_bank_full", bank_full, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_done", done, 0);

      // First fill goes to bank 0, second to bank 1.
      reset = 0; enable = 1;
      step();
      check("first_req", fill_req, 1);
      check("first_bank", write_bank, 0);
      fill_done = 1; step(); fill_done = 0;
      check("first_full", bank_full, 2'b01);
      check("req_gap", fill_req, 0);
      step();
      check("second_req", fill_req, 1);
      check("second_bank", write_bank, 1);
      fill_done = 1; step(); fill_done = 0;
      check("both_full", bank_full, 2'b11);

      // Display bank 1 first, repeat once, then swap to bank 2.
      pulse_fs(0);
      check("show_b1", read_bank1, 1);
      check("show_b1_not_b2", read_bank2, 0);
      check("fc_1", frame_count, 1);
      pulse_fs(0);
      check("repeat_b1", read_bank1, 1);
      check("repeat_fc", frame_count, 1);
      pulse_fs(0);
      check("show_b2", read_bank2, 1);
      check("fc_2", frame_count, 2);
      check("released_b1", bank_full, 2'b10);
      step();
      check("refill_req", fill_req, 1);
      check("refill_bank", write_bank, 0);

      // Fill held off past the swap point, then a fill landing with frame_start.
      pulse_fs(0);
      pulse_fs(0);
      check("underrun_1", underrun_count, 1);
      check("held_b2", read_bank2, 1);
      pulse_fs(1);
      check("underrun_2", underrun_count, 2);
      check("coincident_held", read_bank2, 1);
      check("coincident_full", bank_full, 2'b11);
      pulse_fs(0);
      check("late_swap_b1", read_bank1, 1);
      check("fc_3", frame_count, 3);
      check("late_release", bank_full, 2'b01);
      step();
      check("after_release_req", fill_req, 1);
      check("after_release_bank", write_bank, 1);

      // Reset mid-fill, then a stray fill_done with playback disabled.
      enable = 0; reset = 1;
      step();
      reset = 0; fill_done = 1;
      step();
      fill_done = 0;
      check("mid_rst_full", bank_full, 0);
      check("mid_rst_wb", write_bank, 0);
      check("mid_rst_rd", {read_bank1, read_bank2}, 0);
      check("mid_rst_uc", underrun_count, 0);
      pulses = 0;
      repeat (5) begin
         step();
         if (fill_req) pulses++;
      end
      check("no_req_disabled", pulses, 0);

      // Random traffic until the clip completes.
      fd_cd = 0; fs_cd = $urandom_range(20, 80); off_cnt = 0;
      for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
         step();
         fill_done = 0; frame_start = 0;
         if (fill_req) begin
            pulses++;
            fd_cd = $urandom_range(1, 60);
         end
         if (fd_cd > 0) begin
            fd_cd--;
            if (fd_cd == 0) fill_done = 1;
         end else if ($urandom_range(0, 199) == 0) begin
            fill_done = 1;
         end
         fs_cd--;
         if (fs_cd == 0) begin
            frame_start = 1;
            fs_cd = $urandom_range(20, 80);
         end
         if (off_cnt > 0) begin
            off_cnt--;
            enable = 0;
         end else begin
            enable = 1;
            if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 30);
         end
      end
      step();
      check("total_fill_reqs", pulses, NUM_FRAMES);
      check("clip_done", done, 1);
      check("final_frame_count", frame_count, NUM_FRAMES);
      check("last_bank_shown", read_bank1 ^ read_bank2, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
